// File: rtl/d_cache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with an uncached window.
// Read hits return combinationally; misses refill a whole line one word at a time.
module d_cache_dm #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int UNCACHED_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_en,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        stall,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_data_ok
);

  localparam int LINES      = 1 << INDEX_WIDTH;
  localparam int WORD_WIDTH = OFFSET_WIDTH - 2;
  localparam int WORDS      = 1 << WORD_WIDTH;
  localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REFILL   = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;
  localparam logic [1:0] UNCACHED = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [WORD_WIDTH-1:0] cnt_reg, cnt_next;
  logic [LINES-1:0]      valid_reg;
  logic [TAG_WIDTH-1:0]  tag_mem [0:LINES-1];
  logic [31:0]           data_mem [0:LINES*WORDS-1];

  logic [TAG_WIDTH-1:0]   addr_tag;
  logic [INDEX_WIDTH-1:0] addr_index;
  logic [WORD_WIDTH-1:0]  addr_word;
  logic                   uncached;
  logic                   hit;
  logic                   cnt_last;
  logic                   stall_raw;
  logic [31:0]            line_word;
  logic [31:0]            merged_word;

  assign addr_tag   = data_addr[31:INDEX_WIDTH+OFFSET_WIDTH];
  assign addr_index = data_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign addr_word  = data_addr[OFFSET_WIDTH-1:2];
  assign uncached   = (UNCACHED_EN != 0) && (data_addr[31:29] == 3'b101);
  assign hit        = valid_reg[addr_index] && (tag_mem[addr_index] == addr_tag) && !uncached;
  assign cnt_last   = &cnt_reg;
  assign line_word  = data_mem[{addr_index, addr_word}];

  // Byte-merge of the CPU write into the currently cached word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = data_wen[gi] ? data_wdata[8*gi +: 8] : line_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_raw  = 1'b0;
    data_rdata = line_word;
    mem_addr   = data_addr;
    case (state_reg)
      IDLE: begin
        if (data_en) begin
          if (|data_wen) begin
            state_next = WRITE;
            stall_raw  = 1'b1;
          end else if (uncached) begin
            state_next = UNCACHED;
            stall_raw  = 1'b1;
          end else if (!hit) begin
            state_next = REFILL;
            stall_raw  = 1'b1;
          end
        end
      end
      REFILL: begin
        stall_raw = 1'b1;
        mem_addr  = {data_addr[31:OFFSET_WIDTH], cnt_reg, 2'b00};
        if (mem_data_ok) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_last) state_next = IDLE;
        end
      end
      WRITE: begin
        stall_raw = ~mem_data_ok;
        if (mem_data_ok) state_next = IDLE;
      end
      UNCACHED: begin
        stall_raw  = ~mem_data_ok;
        data_rdata = mem_rdata;
        if (mem_data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating with rst keeps the handshake outputs quiet for the whole reset interval.
  assign stall     = rst & data_en & stall_raw;
  assign mem_en    = rst & (state_reg != IDLE);
  assign mem_wen   = (rst && state_reg == WRITE) ? data_wen : 4'b0000;
  assign mem_wdata = data_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      valid_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Line is invalid from refill start until its last word lands.
      if (state_reg == IDLE && state_next == REFILL)
        valid_reg[addr_index] <= 1'b0;
      if (state_reg == REFILL && mem_data_ok && cnt_last)
        valid_reg[addr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_reg == REFILL && mem_data_ok) begin
      data_mem[{addr_index, cnt_reg}] <= mem_rdata;
      if (cnt_last) tag_mem[addr_index] <= addr_tag;
    end else if (state_reg == WRITE && mem_data_ok && hit) begin
      data_mem[{addr_index, addr_word}] <= merged_word;
    end
  end

endmodule

// File: tb/tb_d_cache_dm.sv
// Directed bench for d_cache_dm: a latency-1 memory responder with a word model,
// one task per scenario with inline comparisons.
module tb_d_cache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_en = 1'b0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        stall;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_data_ok = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [logic [31:0]];
  logic [31:0] log_addr [$];
  logic [3:0]  log_wen [$];
  logic [31:0] log_wdata [$];

  d_cache_dm dut (
    .clk(clk), .rst(rst), .data_en(data_en), .data_addr(data_addr),
    .data_wen(data_wen), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .stall(stall), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model.exists(a)) return model[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory: answers each request one cycle after it appears, logs it at completion.
  initial begin
    int lat;
    logic [31:0] w;
    lat = 0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_data_ok) begin
        mem_data_ok = 1'b0;
      end else if (mem_en) begin
        if (lat >= 1) begin
          log_addr.push_back(mem_addr);
          log_wen.push_back(mem_wen);
          log_wdata.push_back(mem_wdata);
          if (mem_wen == 4'b0000) begin
            mem_rdata = model_rd(mem_addr);
          end else begin
            w = model_rd(mem_addr);
            for (int b = 0; b < 4; b++)
              if (mem_wen[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            model[mem_addr] = w;
          end
          mem_data_ok = 1'b1;
          lat = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_wen.delete();
    log_wdata.delete();
  endtask

  // One CPU access; returns read data and the ok/mem_en levels in the completion cycle.
  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                        output logic [31:0] rd, output logic ok_done,
                        output logic en_done, output int cycles);
    @(negedge clk);
    data_en = 1'b1;
    data_addr = a;
    data_wen = w;
    data_wdata = d;
    cycles = 0;
    #2;
    while (stall && cycles < 200) begin
      @(negedge clk);
      #2;
      cycles++;
    end
    rd = data_rdata;
    ok_done = mem_data_ok;
    en_done = mem_en;
    if (cycles >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL access_timeout addr=%h still stalled after %0d cycles", a, cycles);
    end
    @(negedge clk);
    data_en = 1'b0;
    data_wen = 4'b0000;
  endtask

  task automatic test_reset();
    data_en = 1'b1;
    data_addr = 32'h40;
    data_wen = 4'b0000;
    @(negedge clk);
    #2;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b want=0", stall); end
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en got=%b want=0", mem_en); end
    n_vec++; if (mem_wen !== 4'b0000) begin n_err++; $display("FAIL reset_mem_wen got=%b want=0000", mem_wen); end
    data_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_cold_read();
    logic [31:0] rd; logic ok, en; int cyc;
    clear_log();
    access(32'h40, 4'b0000, 32'h0, rd, ok, en, cyc);
    $display("cold read 0x40 -> %h, %0d mem txns", rd, log_addr.size());
    n_vec++; if (rd !== 32'h11223344) begin n_err++; $display("FAIL cold_rdata got=%h want=11223344", rd); end
    n_vec++; if (log_addr.size() != 4) begin n_err++; $display("FAIL cold_txn_count got=%0d want=4", log_addr.size()); end
    if (log_addr.size() == 4)
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (log_addr[i] !== 32'h40 + 32'(4*i) || log_wen[i] !== 4'b0000) begin
          n_err++; $display("FAIL cold_txn%0d got addr=%h wen=%b want addr=%h wen=0000", i, log_addr[i], log_wen[i], 32'h40 + 32'(4*i));
        end
      end
    clear_log();
    access(32'h48, 4'b0000, 32'h0, rd, ok, en, cyc);
    $display("hit read 0x48 -> %h in %0d cycles", rd, cyc);
    n_vec++; if (rd !== 32'h11223366) begin n_err++; $display("FAIL hit48_rdata got=%h want=11223366", rd); end
    n_vec++; if (cyc != 0 || en !== 1'b0) begin n_err++; $display("FAIL hit48_nostall got cycles=%0d mem_en=%b want 0/0", cyc, en); end
    n_vec++; if (log_addr.size() != 0) begin n_err++; $display("FAIL hit48_no_mem got=%0d want=0", log_addr.size()); end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; logic ok, en; int cyc;
    clear_log();
    access(32'h40, 4'b0011, 32'hAABBCCDD, rd, ok, en, cyc);
    $display("write hit 0x40 wen=0011 -> %0d mem txns", log_addr.size());
    n_vec++; if (log_addr.size() != 1) begin n_err++; $display("FAIL wr_txn_count got=%0d want=1", log_addr.size()); end
    if (log_addr.size() == 1) begin
      n_vec++;
      if (log_addr[0] !== 32'h40 || log_wen[0] !== 4'b0011 || log_wdata[0] !== 32'hAABBCCDD) begin
        n_err++; $display("FAIL wr_txn got addr=%h wen=%b data=%h want 00000040/0011/aabbccdd", log_addr[0], log_wen[0], log_wdata[0]);
      end
    end
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL wr_release got mem_data_ok=%b at stall drop want=1", ok); end
    clear_log();
    access(32'h40, 4'b0000, 32'h0, rd, ok, en, cyc);
    $display("read after write 0x40 -> %h", rd);
    n_vec++; if (rd !== 32'h1122CCDD) begin n_err++; $display("FAIL merge_rdata got=%h want=1122ccdd", rd); end
    n_vec++; if (log_addr.size() != 0 || cyc != 0) begin n_err++; $display("FAIL merge_hit got txns=%0d cycles=%0d want 0/0", log_addr.size(), cyc); end
  endtask

  task automatic test_conflict();
    logic [31:0] rd; logic ok, en; int cyc;
    clear_log();
    access(32'h440, 4'b0000, 32'h0, rd, ok, en, cyc);
    $display("conflict read 0x440 -> %h, %0d mem txns", rd, log_addr.size());
    n_vec++; if (rd !== 32'h0440FBBF) begin n_err++; $display("FAIL conf_rdata got=%h want=0440fbbf", rd); end
    n_vec++; if (log_addr.size() != 4) begin n_err++; $display("FAIL conf_txn_count got=%0d want=4", log_addr.size()); end
    if (log_addr.size() == 4)
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (log_addr[i] !== 32'h440 + 32'(4*i)) begin
          n_err++; $display("FAIL conf_txn%0d got=%h want=%h", i, log_addr[i], 32'h440 + 32'(4*i));
        end
      end
    clear_log();
    access(32'h40, 4'b0000, 32'h0, rd, ok, en, cyc);
    $display("re-read 0x40 -> %h, %0d mem txns", rd, log_addr.size());
    n_vec++; if (log_addr.size() != 4) begin n_err++; $display("FAIL evict_txn_count got=%0d want=4", log_addr.size()); end
    n_vec++; if (rd !== 32'h1122CCDD) begin n_err++; $display("FAIL evict_rdata got=%h want=1122ccdd", rd); end
  endtask

  task automatic test_uncached();
    logic [31:0] rd; logic ok, en; int cyc;
    for (int k = 0; k < 2; k++) begin
      clear_log();
      access(32'hA0000010, 4'b0000, 32'h0, rd, ok, en, cyc);
      $display("uncached read #%0d 0xa0000010 -> %h, %0d mem txns", k, rd, log_addr.size());
      n_vec++; if (log_addr.size() != 1) begin n_err++; $display("FAIL unc%0d_txn_count got=%0d want=1", k, log_addr.size()); end
      if (log_addr.size() == 1) begin
        n_vec++;
        if (log_addr[0] !== 32'hA0000010 || log_wen[0] !== 4'b0000) begin
          n_err++; $display("FAIL unc%0d_txn got addr=%h wen=%b want a0000010/0000", k, log_addr[0], log_wen[0]);
        end
      end
      n_vec++; if (rd !== 32'h0010FFEF) begin n_err++; $display("FAIL unc%0d_rdata got=%h want=0010ffef", k, rd); end
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL unc%0d_release got mem_data_ok=%b want=1", k, ok); end
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd; logic ok, en; int cyc;
    clear_log();
    access(32'h440, 4'b0000, 32'h0, rd, ok, en, cyc);
    clear_log();
    @(negedge clk);
    data_en = 1'b1;
    data_addr = 32'h40;
    data_wen = 4'b0000;
    for (int i = 0; i < 200 && log_addr.size() < 2; i++) begin
      @(negedge clk);
      #2;
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    $display("reset after %0d refill words", log_addr.size());
    n_vec++; if (log_addr.size() != 2) begin n_err++; $display("FAIL mid_words got=%0d want=2", log_addr.size()); end
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL mid_mem_en got=%b want=0", mem_en); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_stall got=%b want=0", stall); end
    data_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    access(32'h40, 4'b0000, 32'h0, rd, ok, en, cyc);
    $display("read 0x40 after reset -> %h, %0d mem txns", rd, log_addr.size());
    n_vec++; if (log_addr.size() != 4) begin n_err++; $display("FAIL post_rst_txn_count got=%0d want=4", log_addr.size()); end
    if (log_addr.size() == 4) begin
      n_vec++; if (log_addr[0] !== 32'h40 || log_addr[3] !== 32'h4C) begin n_err++; $display("FAIL post_rst_addrs got=%h..%h want=40..4c", log_addr[0], log_addr[3]); end
    end
    n_vec++; if (rd !== 32'h1122CCDD) begin n_err++; $display("FAIL post_rst_rdata got=%h want=1122ccdd", rd); end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd; logic ok, en; int cyc;
    clear_log();
    access(32'h100, 4'b1111, 32'hCAFEF00D, rd, ok, en, cyc);
    $display("write miss 0x100 -> %0d mem txns", log_addr.size());
    n_vec++; if (log_addr.size() != 1) begin n_err++; $display("FAIL wmiss_txn_count got=%0d want=1", log_addr.size()); end
    if (log_addr.size() == 1) begin
      n_vec++;
      if (log_addr[0] !== 32'h100 || log_wen[0] !== 4'b1111 || log_wdata[0] !== 32'hCAFEF00D) begin
        n_err++; $display("FAIL wmiss_txn got addr=%h wen=%b data=%h want 00000100/1111/cafef00d", log_addr[0], log_wen[0], log_wdata[0]);
      end
    end
    clear_log();
    access(32'h100, 4'b0000, 32'h0, rd, ok, en, cyc);
    $display("read 0x100 -> %h, %0d mem txns", rd, log_addr.size());
    n_vec++; if (log_addr.size() != 4) begin n_err++; $display("FAIL wmiss_refill got=%0d want=4", log_addr.size()); end
    n_vec++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL wmiss_rdata got=%h want=cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic ok, en; int cyc;
    logic [31:0] want [4];
    want[0] = 32'hCAFEF00D; want[1] = 32'h0104FEFB; want[2] = 32'h0108FEF7; want[3] = 32'h010CFEF3;
    clear_log();
    for (int i = 0; i < 4; i++) begin
      access(32'h100 + 32'(4*i), 4'b0000, 32'h0, rd, ok, en, cyc);
      $display("hit read %h -> %h in %0d cycles", 32'h100 + 32'(4*i), rd, cyc);
      n_vec++;
      if (rd !== want[i] || cyc != 0) begin
        n_err++; $display("FAIL b2b%0d got=%h cycles=%0d want=%h cycles=0", i, rd, cyc, want[i]);
      end
    end
    n_vec++; if (log_addr.size() != 0) begin n_err++; $display("FAIL b2b_no_mem got=%0d want=0", log_addr.size()); end
  endtask

  initial begin
    model[32'h40] = 32'h11223344;
    model[32'h44] = 32'h11223355;
    model[32'h48] = 32'h11223366;
    model[32'h4C] = 32'h11223377;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_conflict();
    test_uncached();
    test_reset_mid_refill();
    test_write_miss();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
